// File: rtl/pwl_pkg.sv
// pwl_pkg
// Shared helpers for the piecewise-linear mapper: a constant-evaluable clog2,
// the default geometry of the mapper and the widths derived from it, and the
// table entry layout at default widths.
// No ports (package).

package pwl_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of a select field; a single-entry selector still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int DEF_CH      = 4;
  localparam int DEF_LANES   = 8;
  localparam int DEF_IN_W    = 6;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_NSEG    = 8;
  localparam int DEF_SLOPE_W = 6;
  localparam int DEF_SHIFT   = 0;

  localparam int SEG_W  = clog2(DEF_NSEG);
  localparam int OFF_W  = DEF_IN_W - SEG_W;
  localparam int PROD_W = DEF_OUT_W + DEF_SLOPE_W + OFF_W + 1;

  typedef struct packed {
    logic signed [DEF_OUT_W-1:0]   base;
    logic signed [DEF_SLOPE_W-1:0] slope;
  } seg_entry_t;

endpackage

// File: rtl/pwl_lane.sv
// pwl_lane
// Combinational math between S1 and S2 for one lane:
//   sum = base + ((slope * off) >>> SHIFT), clamped to the signed OUT_W range.
// Ports:
//   i_base  signed OUT_W    segment base from the S1 register
//   i_slope signed SLOPE_W  segment slope from the S1 register
//   i_off   unsigned OFF_W  offset within the segment
//   o_data  signed OUT_W    clamped result
//   o_sat   1               result was clamped

module pwl_lane #(
  parameter int OUT_W   = 8,
  parameter int SLOPE_W = 6,
  parameter int OFF_W   = 3,
  parameter int SHIFT   = 0
) (
  input  logic signed [OUT_W-1:0]   i_base,
  input  logic signed [SLOPE_W-1:0] i_slope,
  input  logic        [OFF_W-1:0]   i_off,
  output logic signed [OUT_W-1:0]   o_data,
  output logic                      o_sat
);

  localparam int PROD_W = OUT_W + SLOPE_W + OFF_W + 1;

  logic signed [PROD_W-1:0] w_slope_x;
  logic signed [PROD_W-1:0] w_off_x;
  logic signed [PROD_W-1:0] w_base_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_sum;

  assign w_slope_x = {{(PROD_W-SLOPE_W){i_slope[SLOPE_W-1]}}, i_slope};
  assign w_off_x   = {{(PROD_W-OFF_W){1'b0}}, i_off};
  assign w_base_x  = {{(PROD_W-OUT_W){i_base[OUT_W-1]}}, i_base};
  assign w_prod    = w_slope_x * w_off_x;
  assign w_sum     = w_base_x + (w_prod >>> SHIFT);

  // The sum fits in OUT_W bits exactly when every bit from the OUT_W-1
  // position upward matches the sign bit.
  always_comb begin
    o_data = w_sum[OUT_W-1:0];
    o_sat  = 1'b0;
    if (w_sum[PROD_W-1:OUT_W-1] != {(PROD_W-OUT_W+1){w_sum[PROD_W-1]}}) begin
      o_sat  = 1'b1;
      o_data = w_sum[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pwl_map_array.sv
// pwl_map_array
// Maps CH x LANES unsigned IN_W-bit codes to signed OUT_W-bit samples through
// per-channel NSEG-segment piecewise-linear tables (shadow/active pair).
// Two-stage pipeline: S1 = table lookup, S2 = clamped result.
// Optional macro PWL_SAT_CNT_EN builds per-channel 16-bit saturation counters;
// without it sat_cnt is tied to zero.
// Ports:
//   clk, arst (async, active-high), clr (sync pipeline clear)
//   in_valid, in_data            input vector, lane l of ch c at (c*LANES+l)*IN_W
//   out_valid, out_data, out_sat mapped vector, same packing, sat flag per lane
//   cfg_we, cfg_ch, cfg_seg, cfg_base, cfg_slope  shadow entry write
//   cfg_commit                   copy all shadow tables to active
//   sat_cnt                      16 bits per channel

module pwl_map_array
  import pwl_pkg::*;
#(
  parameter int CH      = DEF_CH,
  parameter int LANES   = DEF_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int NSEG    = DEF_NSEG,
  parameter int SLOPE_W = DEF_SLOPE_W,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic [CH*LANES*IN_W-1:0]     in_data,
  output logic                         out_valid,
  output logic [CH*LANES*OUT_W-1:0]    out_data,
  output logic [CH*LANES-1:0]          out_sat,
  input  logic                         cfg_we,
  input  logic [idx_w(CH)-1:0]         cfg_ch,
  input  logic [idx_w(NSEG)-1:0]       cfg_seg,
  input  logic signed [OUT_W-1:0]      cfg_base,
  input  logic signed [SLOPE_W-1:0]    cfg_slope,
  input  logic                         cfg_commit,
  output logic [CH*16-1:0]             sat_cnt
);

  localparam int NL      = CH * LANES;
  localparam int CH_W    = idx_w(CH);
  localparam int L_SEG_W = idx_w(NSEG);
  localparam int L_OFF_W = IN_W - L_SEG_W;

  typedef struct packed {
    logic signed [OUT_W-1:0]   base;
    logic signed [SLOPE_W-1:0] slope;
  } entry_t;

  // ---------------- tables ----------------
  entry_t r_shadow     [CH][NSEG];
  entry_t r_active     [CH][NSEG];
  entry_t w_shadow_nxt [CH][NSEG];
  logic   w_cfg_hit;

  // Drops writes aimed past the last channel when CH is not a power of 2.
  assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < (CH_W+1)'(CH));

  // Commit copies this next-shadow view, so a write in the commit cycle
  // lands in the active table as well.
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int c = 0; c < CH; c++) begin
      for (int s = 0; s < NSEG; s++) begin
        if (w_cfg_hit && cfg_ch == CH_W'(c) && cfg_seg == L_SEG_W'(s)) begin
          w_shadow_nxt[c][s].base  = cfg_base;
          w_shadow_nxt[c][s].slope = cfg_slope;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int c = 0; c < CH; c++) begin
        for (int s = 0; s < NSEG; s++) begin
          r_shadow[c][s] <= '0;
          r_active[c][s] <= '0;
        end
      end
    end else begin
      r_shadow <= w_shadow_nxt;
      if (cfg_commit) r_active <= w_shadow_nxt;
    end
  end

  // ---------------- lanes ----------------
  logic [L_SEG_W-1:0] w_seg     [NL];
  logic [L_OFF_W-1:0] w_off     [NL];
  logic [L_OFF_W-1:0] r_s1_off  [NL];
  entry_t             r_s1_ent  [NL];
  logic [OUT_W-1:0]   w_res     [NL];
  logic [OUT_W-1:0]   r_s2_data [NL];
  logic [NL-1:0]      w_sat;
  logic [NL-1:0]      r_s2_sat;
  logic               r_s1_valid;
  logic               r_s2_valid;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    assign w_seg[gi] = in_data[gi*IN_W + IN_W - 1 -: L_SEG_W];
    assign w_off[gi] = in_data[gi*IN_W +: L_OFF_W];

    pwl_lane #(
      .OUT_W   (OUT_W),
      .SLOPE_W (SLOPE_W),
      .OFF_W   (L_OFF_W),
      .SHIFT   (SHIFT)
    ) u_lane (
      .i_base  (r_s1_ent[gi].base),
      .i_slope (r_s1_ent[gi].slope),
      .i_off   (r_s1_off[gi]),
      .o_data  (w_res[gi]),
      .o_sat   (w_sat[gi])
    );

    assign out_data[gi*OUT_W +: OUT_W] = r_s2_data[gi];
  end

  // Stage data registers load only on valid cycles, so the output holds
  // through gaps; only the valid bits advance every cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sat   <= '0;
      for (int i = 0; i < NL; i++) begin
        r_s1_off[i]  <= '0;
        r_s1_ent[i]  <= '0;
        r_s2_data[i] <= '0;
      end
    end else if (clr) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sat   <= '0;
      for (int i = 0; i < NL; i++) r_s2_data[i] <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      if (in_valid) begin
        for (int i = 0; i < NL; i++) begin
          r_s1_off[i] <= w_off[i];
          r_s1_ent[i] <= r_active[i / LANES][w_seg[i]];
        end
      end
      if (r_s1_valid) begin
        r_s2_sat <= w_sat;
        for (int i = 0; i < NL; i++) r_s2_data[i] <= w_res[i];
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sat   = r_s2_sat;

  // ---------------- saturation counters ----------------
`ifdef PWL_SAT_CNT_EN
  localparam int CNT_W = clog2(LANES + 1);

  logic [CNT_W-1:0] w_nsat    [CH];
  logic [16:0]      w_cnt_sum [CH];
  logic [15:0]      w_cnt_nxt [CH];
  logic [15:0]      r_sat_cnt [CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_nsat[c]    = '0;
      w_cnt_sum[c] = '0;
      w_cnt_nxt[c] = '0;
    end
    for (int c = 0; c < CH; c++) begin
      for (int l = 0; l < LANES; l++) begin
        w_nsat[c] = w_nsat[c] + CNT_W'(w_sat[c*LANES + l]);
      end
      w_cnt_sum[c] = {1'b0, r_sat_cnt[c]} + 17'(w_nsat[c]);
      w_cnt_nxt[c] = w_cnt_sum[c][16] ? 16'hFFFF : w_cnt_sum[c][15:0];
    end
  end

  // Counts the lanes that are being registered into S2 this edge, i.e. the
  // lanes flagged in the out_valid cycle that follows.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int c = 0; c < CH; c++) r_sat_cnt[c] <= '0;
    end else if (clr) begin
      for (int c = 0; c < CH; c++) r_sat_cnt[c] <= '0;
    end else if (r_s1_valid) begin
      for (int c = 0; c < CH; c++) r_sat_cnt[c] <= w_cnt_nxt[c];
    end
  end

  for (genvar gc = 0; gc < CH; gc++) begin : g_cnt
    assign sat_cnt[gc*16 +: 16] = r_sat_cnt[gc];
  end
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_pwl_map_array.sv
module tb_pwl_map_array;

  localparam int CH = 4, LANES = 8, IN_W = 6, OUT_W = 8, NSEG = 8, SLOPE_W = 6;
  localparam int NL = CH * LANES;

  logic                     clk = 1'b0;
  logic                     arst = 1'b1;
  logic                     clr = 1'b0;
  logic                     in_valid = 1'b0;
  logic [NL*IN_W-1:0]       in_data = '0;
  logic                     out_valid;
  logic [NL*OUT_W-1:0]      out_data;
  logic [NL-1:0]            out_sat;
  logic                     cfg_we = 1'b0;
  logic [1:0]               cfg_ch = '0;
  logic [2:0]               cfg_seg = '0;
  logic signed [OUT_W-1:0]  cfg_base = '0;
  logic signed [SLOPE_W-1:0] cfg_slope = '0;
  logic                     cfg_commit = 1'b0;
  logic [CH*16-1:0]         sat_cnt;

  pwl_map_array dut (
    .clk        (clk),
    .arst       (arst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_seg    (cfg_seg),
    .cfg_base   (cfg_base),
    .cfg_slope  (cfg_slope),
    .cfg_commit (cfg_commit),
    .sat_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NL*OUT_W-1:0] data;
    logic [NL-1:0]       sat;
    int                  at;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic               gap_chk = 1'b0;
  logic [NL*OUT_W-1:0] last_data = '0;
  exp_t               m_e;

  always @(negedge clk) begin
    if (!arst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: out_valid=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          m_e = q.pop_front();
          chk("out_data", out_data, m_e.data);
          chk("out_sat", out_sat, m_e.sat);
          chk("latency", cyc, m_e.at);
        end
        last_data = out_data;
      end else if (gap_chk) begin
        chk("hold_in_gap", out_data, last_data);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle();
    @(negedge clk);
    in_valid   = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int seg, input int base, input int slope,
                           input bit commit);
    @(negedge clk);
    in_valid   = 1'b0;
    clr        = 1'b0;
    cfg_we     = 1'b1;
    cfg_ch     = ch[1:0];
    cfg_seg    = seg[2:0];
    cfg_base   = base[7:0];
    cfg_slope  = slope[5:0];
    cfg_commit = commit;
  endtask

  task automatic commit_only();
    @(negedge clk);
    in_valid   = 1'b0;
    cfg_we     = 1'b0;
    clr        = 1'b0;
    cfg_commit = 1'b1;
  endtask

  // Lanes not named get code 48 (segment 6, never programmed), mapping to 0.
  task automatic send(input int i0, input int c0, input int e0, input bit s0,
                      input int i1, input int c1, input int e1, input bit s1,
                      input bit push);
    logic [NL*IN_W-1:0] vin;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < NL; k++) vin[k*IN_W +: IN_W] = 6'd48;
    vin[i0*IN_W +: IN_W] = c0[5:0];
    if (i1 >= 0) vin[i1*IN_W +: IN_W] = c1[5:0];
    in_data    = vin;
    in_valid   = 1'b1;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    clr        = 1'b0;
    if (push) begin
      e.data = '0;
      e.sat  = '0;
      e.data[i0*OUT_W +: OUT_W] = e0[7:0];
      e.sat[i0] = s0;
      if (i1 >= 0) begin
        e.data[i1*OUT_W +: OUT_W] = e1[7:0];
        e.sat[i1] = s1;
      end
      e.at = cyc + 2;
      q.push_back(e);
    end
  endtask

  logic [CH*16-1:0] exp_cnt;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    arst = 1'b0;

    // reset defaults: zeroed tables map everything to 0
    send(0, 21, 0, 0, 5, 63, 0, 0, 1);
    repeat (3) idle();

    // basic map: ch0 seg2 base -20 slope 3
    cfg_write(0, 2, -20, 3, 0);
    commit_only();
    send(0, 21, -5, 0, 7, 23, 1, 0, 1);
    repeat (3) idle();

    // saturation in ch1
    cfg_write(1, 7, 120, 5, 0);
    cfg_write(1, 0, -120, -4, 0);
    commit_only();
    send(8, 63, 127, 1, 9, 56, 120, 0, 1);
    send(8, 7, -128, 1, 15, 0, -120, 0, 1);
    repeat (3) idle();
`ifdef PWL_SAT_CNT_EN
    exp_cnt = 64'h0000_0000_0002_0000;
`else
    exp_cnt = 64'h0;
`endif
    chk("sat_cnt_after_sat", sat_cnt, exp_cnt);

    // commit timing in ch2
    cfg_write(2, 1, 10, 2, 0);
    send(16, 9, 0, 0, -1, 0, 0, 0, 1);
    send(16, 9, 0, 0, -1, 0, 0, 0, 1);
    cfg_commit = 1'b1;
    send(16, 9, 12, 0, -1, 0, 0, 0, 1);
    send(17, 26, 0, 0, -1, 0, 0, 0, 1);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_seg = 3'd3; cfg_base = 8'sd5; cfg_slope = 6'sd1;
    cfg_commit = 1'b1;
    send(17, 26, 7, 0, -1, 0, 0, 0, 1);
    repeat (3) idle();

    // stream with gaps: ch0 lane0 walks segment 2, ch3 lane7 stays in seg 6
    gap_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 != 2) send(0, 16 + (i % 8), -20 + 3 * (i % 8), 0, 31, 48 + (i % 8), 0, 0, 1);
      else idle();
    end
    repeat (4) idle();
    gap_chk = 1'b0;

    // clr with two samples in flight
    send(0, 21, -5, 0, -1, 0, 0, 0, 0);
    send(0, 21, -5, 0, -1, 0, 0, 0, 0);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("clr_out_valid", out_valid, 0);
    end
    chk("clr_out_data", out_data, 0);
    chk("clr_sat_cnt", sat_cnt, 0);
    send(0, 21, -5, 0, 8, 63, 127, 1, 1);
    repeat (3) idle();

    // arst mid-stream
    send(0, 21, -5, 0, -1, 0, 0, 0, 0);
    @(posedge clk);
    #2 arst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_sat", out_sat, 0);
    @(negedge clk);
    arst = 1'b0;
    send(0, 21, 0, 0, 8, 63, 0, 0, 1);
    repeat (3) idle();

    // bounded drain
    for (int k = 0; k < 20 && q.size() != 0; k++) idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
